// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result bundle of the bit-serial subtractor.
// The master drives start and operands; the slave returns status and result.
interface serial_subtractor_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtract cell reused LSB-first over
// WIDTH cycles, wrapped in a start/busy/done handshake with held results.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             br;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    logic             a_i;
    logic             b_i;
    logic             hs_d;
    logic             hs_b;
    logic             cell_d;
    logic             cell_b;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Full-subtract cell: two half-subtractors chained through the running borrow.
    always_comb begin
        a_i      = a_sh[0];
        b_i      = b_sh[0];
        hs_d     = a_i ^ b_i;
        hs_b     = ~a_i & b_i;
        cell_d   = hs_d ^ br;
        cell_b   = ~hs_d & br;
        br_next  = hs_b | cell_b;
        res_next = (res >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            br         <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_next;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // Results publish only on completion, so they hold across a new operation.
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                        zero       <= (res_next == '0);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff;
    assign bus.borrow_out = borrow_out;
    assign bus.zero       = zero;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: WIDTH=8 and WIDTH=1 instances checked
// cycle-by-cycle against an arithmetic reference (a - b, a < b).
module tb_serial_subtractor_ctrl;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(W)) i8 ();
    serial_subtractor_ctrl_if #(.WIDTH(1)) i1 ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    int passed = 0;
    int total  = 0;

    logic [W-1:0] exp_diff   = '0;
    logic         exp_borrow = 1'b0;
    logic         exp_zero   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_diff   = a - b;
        exp_borrow = (a < b);
        exp_zero   = (exp_diff == '0);
    endfunction

    // One WIDTH=8 operation; inject pulses ignored start during SHIFT and DONE.
    task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [W-1:0] pd;
        logic         pb;
        logic         pz;
        pd = exp_diff;
        pb = exp_borrow;
        pz = exp_zero;
        @(negedge clk);
        i8.start = 1'b1;
        i8.a     = a;
        i8.b     = b;
        @(posedge clk); #1;
        i8.start = 1'b0;
        i8.a     = W'($urandom);
        i8.b     = W'($urandom);
        chk("accept_busy", 32'(i8.busy), 32'd1);
        chk("accept_done", 32'(i8.done), 32'd0);
        for (int i = 1; i < int'(W); i++) begin
            if (inject && i == 3) begin
                i8.start = 1'b1;
                i8.a     = '0;
                i8.b     = '1;
            end
            @(posedge clk); #1;
            if (inject && i == 3) i8.start = 1'b0;
            chk("shift_busy", 32'(i8.busy), 32'd1);
            chk("shift_done", 32'(i8.done), 32'd0);
            chk("shift_hold_diff", 32'(i8.diff), 32'(pd));
            chk("shift_hold_flags", 32'({i8.borrow_out, i8.zero}), 32'({pb, pz}));
        end
        model(a, b);
        @(posedge clk); #1;
        chk("done_pulse", 32'(i8.done), 32'd1);
        chk("done_busy", 32'(i8.busy), 32'd0);
        chk("diff", 32'(i8.diff), 32'(exp_diff));
        chk("borrow_out", 32'(i8.borrow_out), 32'(exp_borrow));
        chk("zero", 32'(i8.zero), 32'(exp_zero));
        if (inject) begin
            i8.start = 1'b1;
            i8.a     = '0;
            i8.b     = '1;
        end
        @(posedge clk); #1;
        i8.start = 1'b0;
        chk("after_done", 32'(i8.done), 32'd0);
        chk("after_busy", 32'(i8.busy), 32'd0);
        chk("after_diff", 32'(i8.diff), 32'(exp_diff));
    endtask

    task automatic op1(input logic a, input logic b);
        logic d;
        logic br;
        d  = a ^ b;
        br = (a == 1'b0) && (b == 1'b1);
        @(negedge clk);
        i1.start = 1'b1;
        i1.a     = a;
        i1.b     = b;
        @(posedge clk); #1;
        i1.start = 1'b0;
        chk("w1_busy", 32'(i1.busy), 32'd1);
        chk("w1_early_done", 32'(i1.done), 32'd0);
        @(posedge clk); #1;
        chk("w1_done", 32'(i1.done), 32'd1);
        chk("w1_diff", 32'(i1.diff), 32'(d));
        chk("w1_borrow", 32'(i1.borrow_out), 32'(br));
        chk("w1_zero", 32'(i1.zero), 32'(d == 1'b0));
        @(posedge clk); #1;
        chk("w1_done_clear", 32'(i1.done), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        i8.start = 1'b0;
        i8.a     = '0;
        i8.b     = '0;
        i1.start = 1'b0;
        i1.a     = '0;
        i1.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w8", 32'({i8.busy, i8.done, i8.borrow_out, i8.zero}), 32'd0);
        chk("rst_w8_diff", 32'(i8.diff), 32'd0);
        chk("rst_w1", 32'({i1.busy, i1.done, i1.diff, i1.borrow_out, i1.zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start held low must leave the block idle.
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", 32'({i8.busy, i8.done}), 32'd0);

        op8(8'h05, 8'h03, 1'b0);
        op8(8'h03, 8'h05, 1'b0);
        op8(8'h5A, 8'h5A, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'hFF, 8'h00, 1'b0);
        op8(8'h10, 8'h01, 1'b1);
        op8(8'h80, 8'h7F, 1'b0);
        for (int n = 0; n < 20; n++) op8(W'($urandom), W'($urandom), 1'b0);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        i8.start = 1'b1;
        i8.a     = 8'h33;
        i8.b     = 8'h11;
        @(posedge clk); #1;
        i8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 32'({i8.busy, i8.done, i8.borrow_out, i8.zero}), 32'd0);
        chk("abort_diff", 32'(i8.diff), 32'd0);
        exp_diff   = '0;
        exp_borrow = 1'b0;
        exp_zero   = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("in_reset", 32'({i8.busy, i8.done}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", 32'({i8.busy, i8.done}), 32'd0);
        end
        op8(8'h20, 8'h08, 1'b0);

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
